// File: rtl/onehot_pkg.sv
// Shared types and helpers for the debounced one-hot encoder.
package onehot_pkg;

  typedef enum logic [1:0] {
    IN_ZERO,
    IN_ONEHOT,
    IN_MULTI
  } in_class_t;

  // $clog2 that never returns 0, so a counter always has at least one bit.
  function automatic int safe_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/onehot_debounce_encoder_if.sv
// Pin-side bundle of the debounced one-hot encoder.
interface onehot_debounce_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  // No backpressure: valid is a level (some code accepted since reset/clr),
  // new_code is a single-cycle strobe the consumer must sample every cycle.
  logic [N-1:0] in;
  logic         clr;
  logic [W-1:0] out;
  logic         valid;
  logic         new_code;
  logic         err;

  modport master (
    output in, clr,
    input  out, valid, new_code, err
  );

  modport slave (
    input  in, clr,
    output out, valid, new_code, err
  );

endinterface

// File: rtl/onehot_classify.sv
// Combinational classifier: lowest set index plus zero / one-hot / multi-hot class.
module onehot_classify
  import onehot_pkg::*;
#(
  parameter  int N             = 8,
  parameter  int PRIORITY_MODE = 0,
  localparam int W             = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output in_class_t    cls
);

  logic found;
  int   pop;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pop   = 0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        pop = pop + 1;
        if (!found) begin
          idx   = W'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Priority mode folds multi-hot into one-hot at the lowest set index.
  always_comb begin
    cls = IN_ZERO;
    if (pop == 1)
      cls = IN_ONEHOT;
    else if (pop > 1)
      cls = (PRIORITY_MODE != 0) ? IN_ONEHOT : IN_MULTI;
  end

endmodule

// File: rtl/onehot_debounce_encoder.sv
// Synchronise, debounce and encode N one-hot request lines into a latched binary code.
module onehot_debounce_encoder
  import onehot_pkg::*;
#(
  parameter  int N             = 8,
  parameter  int STABLE_CYCLES = 4,
  parameter  int DEFAULT_CODE  = N - 1,
  parameter  int PRIORITY_MODE = 0,
  localparam int W             = $clog2(N)
) (
  input logic                     clk,
  input logic                     rst_n,
  onehot_debounce_encoder_if.slave bus
);

  localparam int             CW      = safe_clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ACC = CW'(STABLE_CYCLES - 1);
  localparam logic [W-1:0]   DEF     = W'(DEFAULT_CODE);

  logic [N-1:0]  s1, s2, prev;
  logic [CW-1:0] cnt;
  logic [W-1:0]  out_q;
  logic          valid_q, new_q, err_q;

  logic          stable, accept;
  logic [W-1:0]  cls_idx;
  in_class_t     cls;

  assign stable = (s2 == prev);
  // Fires on the single edge where the counter crosses into saturation.
  assign accept = stable && (cnt == CNT_ACC);

  onehot_classify #(
    .N             (N),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_classify (
    .vec (s2),
    .idx (cls_idx),
    .cls (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      cnt     <= '0;
      out_q   <= DEF;
      valid_q <= 1'b0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1    <= bus.in;
      s2    <= s1;
      prev  <= s2;
      new_q <= 1'b0;
      if (bus.clr) begin
        out_q   <= DEF;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        cnt     <= '0;
      end else begin
        if (!stable)
          cnt <= '0;
        else if (cnt < CNT_SAT)
          cnt <= cnt + 1'b1;

        if (accept) begin
          case (cls)
            IN_ONEHOT: begin
              out_q   <= cls_idx;
              valid_q <= 1'b1;
              new_q   <= !valid_q || (out_q != cls_idx);
            end
            IN_MULTI: err_q <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.out      = out_q;
  assign bus.valid    = valid_q;
  assign bus.new_code = new_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_onehot_debounce_encoder.sv
// Directed bench: strict and priority instances share one stimulus stream.
module tb_onehot_debounce_encoder;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [5:0] obs;
  logic [5:0] expv;

  onehot_debounce_encoder_if #(.N(N)) bus_s ();
  onehot_debounce_encoder_if #(.N(N)) bus_p ();

  onehot_debounce_encoder #(.N(N), .STABLE_CYCLES(4), .PRIORITY_MODE(0)) u_strict (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  onehot_debounce_encoder #(.N(N), .STABLE_CYCLES(4), .PRIORITY_MODE(1)) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    bus_s.in = v;
    bus_p.in = v;
  endtask

  // clr is sampled by exactly one edge; returns #1 after that edge
  task automatic pulse_clr();
    @(negedge clk);
    bus_s.clr = 1'b1;
    bus_p.clr = 1'b1;
    tick();
    bus_s.clr = 1'b0;
    bus_p.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus_s.in  = '0;
    bus_p.in  = '0;
    bus_s.clr = 1'b0;
    bus_p.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
    expv = {3'd7, 3'b000};
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_hold out/valid/new/err got=%b req=%b", obs, expv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 50; e++) begin
      tick();
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      expv = {3'd7, 3'b000};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL idle cyc=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
  endtask

  task automatic test_glitch();
    drive(8'h04);
    repeat (3) tick();
    drive(8'h00);
    for (int e = 0; e < 10; e++) begin
      tick();
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      expv = {3'd7, 3'b000};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
  endtask

  task automatic test_accept();
    drive(8'h04);
    for (int e = 0; e < 10; e++) begin
      tick();
      expv = {(e >= 6) ? 3'd2 : 3'd7, e >= 6, e == 6, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL accept_strict edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
      obs = {bus_p.out, bus_p.valid, bus_p.new_code, bus_p.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL accept_prio edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
  endtask

  task automatic test_multi_hot();
    drive(8'h12);
    for (int e = 0; e < 10; e++) begin
      tick();
      expv = {3'd2, 1'b1, 1'b0, e >= 6};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL multi_strict edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
      expv = {(e >= 6) ? 3'd1 : 3'd2, 1'b1, e == 6, 1'b0};
      obs  = {bus_p.out, bus_p.valid, bus_p.new_code, bus_p.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL multi_prio edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
    pulse_clr();
    expv = {3'd7, 3'b000};
    obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL clr_strict out/valid/new/err got=%b req=%b", obs, expv);
    end
    obs = {bus_p.out, bus_p.valid, bus_p.new_code, bus_p.err};
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL clr_prio out/valid/new/err got=%b req=%b", obs, expv);
    end
    // released before the post-clr re-accept can happen
    drive(8'h00);
    repeat (10) tick();
    obs = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL clr_settled out/valid/new/err got=%b req=%b", obs, expv);
    end
  endtask

  task automatic test_back_to_back();
    drive(8'h04);
    for (int e = 0; e < 10; e++) begin
      tick();
      expv = {(e >= 6) ? 3'd2 : 3'd7, e >= 6, e == 6, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL first2 edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
    drive(8'h00);
    repeat (10) tick();
    drive(8'h04);
    for (int e = 0; e < 10; e++) begin
      tick();
      expv = {3'd2, 1'b1, 1'b0, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL repeat2 edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
    drive(8'h20);
    for (int e = 0; e < 10; e++) begin
      tick();
      expv = {(e >= 6) ? 3'd5 : 3'd2, 1'b1, e == 6, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL change5 edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
    pulse_clr();
    // k counts edges after the clr edge; the clr edge itself plus four more makes STABLE_CYCLES+1
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      expv = {(k >= 4) ? 3'd5 : 3'd7, k >= 4, k == 4, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reaccept k=%0d out/valid/new/err got=%b req=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_clr_beats_accept();
    drive(8'h01);
    repeat (6) tick();
    @(negedge clk);
    bus_s.clr = 1'b1;
    bus_p.clr = 1'b1;
    tick();
    bus_s.clr = 1'b0;
    bus_p.clr = 1'b0;
    for (int e = 6; e < 12; e++) begin
      if (e > 6) tick();
      expv = {(e >= 10) ? 3'd0 : 3'd7, e >= 10, e == 10, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL clr_vs_accept edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    drive(8'h08);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    expv = {3'd7, 3'b000};
    obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL async_reset out/valid/new/err got=%b req=%b", obs, expv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      expv = {(e >= 6) ? 3'd3 : 3'd7, e >= 6, e == 6, 1'b0};
      obs  = {bus_s.out, bus_s.valid, bus_s.new_code, bus_s.err};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reset_mid edge=%0d out/valid/new/err got=%b req=%b", e, obs, expv);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_glitch();
    test_accept();
    test_multi_hot();
    test_back_to_back();
    test_clr_beats_accept();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
